// File: rtl/fighter_gfx_pkg.sv
// Shared definitions for the fighter graphics pixel stages.
// Contents:
//   SPR_W/SPR_H  sprite dimensions in pixels
//   COLOR_W      colour width (4 bits per R/G/B channel)
//   HP_W         health value width
//   hp_state_e   health animation state encoding
//   dim()        halves every colour channel independently
package fighter_gfx_pkg;

  localparam int SPR_W   = 64;
  localparam int SPR_H   = 64;
  localparam int COLOR_W = 12;
  localparam int HP_W    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HEAL  = 2'd2,
    KO    = 2'd3
  } hp_state_e;

  // Shift each 4-bit channel right by one; the injected zero at the top of
  // each nibble keeps channels from bleeding into their neighbour.
  function automatic logic [COLOR_W-1:0] dim(input logic [COLOR_W-1:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

// File: rtl/health_bar_renderer_if.sv
// Signal bundle between the player-level logic and the health bar renderer.
// Pixel side : video_on, x, y in; rom_row/rom_col out to the sprite ROM,
//              rom_data back from it; rgb_out/bar_on to the pixel mux.
// Health side: frame_tick, hp_load, hp_target_in in; hp_shown, ko out.
// Modports   : slave = the renderer, master = whoever drives it.
interface health_bar_renderer_if;
  import fighter_gfx_pkg::*;

  logic               video_on;
  logic [9:0]         x;
  logic [9:0]         y;
  logic               frame_tick;
  logic               hp_load;
  logic [HP_W-1:0]    hp_target_in;
  logic [5:0]         rom_row;
  logic [5:0]         rom_col;
  logic [COLOR_W-1:0] rom_data;
  logic [COLOR_W-1:0] rgb_out;
  logic               bar_on;
  logic [HP_W-1:0]    hp_shown;
  logic               ko;

  modport slave (
    input  video_on, x, y, frame_tick, hp_load, hp_target_in, rom_data,
    output rom_row, rom_col, rgb_out, bar_on, hp_shown, ko
  );

  modport master (
    output video_on, x, y, frame_tick, hp_load, hp_target_in, rom_data,
    input  rom_row, rom_col, rgb_out, bar_on, hp_shown, ko
  );

endinterface

// File: rtl/health_bar_renderer_hp_animator.sv
// Health animation: walks the displayed health toward the latched target
// one point every STEP_FRAMES frame ticks, and flags knock-out.
// Ports:
//   clk, reset_n        pixel clock, asynchronous active-low reset
//   frame_tick          one pulse per frame
//   hp_load             latch hp_target_in (clamped to MAX_HP)
//   hp_target_in        requested health
//   hp_shown            displayed health (registered)
//   ko                  one-cycle pulse on the cycle health first shows 0
module hp_animator
  import fighter_gfx_pkg::*;
#(
  parameter logic [HP_W-1:0] MAX_HP      = 7'd64,
  parameter logic [3:0]      STEP_FRAMES = 4'd2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            frame_tick,
  input  logic            hp_load,
  input  logic [HP_W-1:0] hp_target_in,
  output logic [HP_W-1:0] hp_shown,
  output logic            ko
);

  hp_state_e       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [HP_W-1:0] target_q, target_d;
  logic            ko_q, ko_d;
  logic [HP_W-1:0] clamped;
  logic [HP_W-1:0] next_hp;

  assign clamped = (hp_target_in > MAX_HP) ? MAX_HP : hp_target_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hp_q     <= MAX_HP;
      target_q <= MAX_HP;
      ko_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      target_q <= target_d;
      ko_q     <= ko_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hp_d     = hp_q;
    target_d = target_q;
    ko_d     = 1'b0;
    next_hp  = hp_q;

    if (hp_load) begin
      // A load restarts the step cadence; a coincident tick is dropped.
      target_d = clamped;
      cnt_d    = '0;
      if (state_q == KO && clamped == '0) begin
        state_d = KO;   // re-loading zero while down must not re-pulse ko
      end else if (clamped < hp_q) begin
        state_d = DRAIN;
      end else if (clamped > hp_q) begin
        state_d = HEAL;
      end else begin
        state_d = IDLE;
      end
    end else if ((state_q == DRAIN || state_q == HEAL) && frame_tick) begin
      if (cnt_q == STEP_FRAMES - 4'd1) begin
        cnt_d   = '0;
        // Direction is only entered when target differs from hp, so the
        // step can never wrap below 0 or climb past MAX_HP.
        next_hp = (state_q == DRAIN) ? hp_q - 7'd1 : hp_q + 7'd1;
        hp_d    = next_hp;
        if (next_hp == target_q) begin
          if (state_q == DRAIN && next_hp == '0) begin
            state_d = KO;
            ko_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign hp_shown = hp_q;
  assign ko       = ko_q;

endmodule

// File: rtl/health_bar_renderer.sv
// Health bar pixel stage. Maps the scan position onto the 64x64 sprite ROM,
// waits out the ROM's one-cycle read latency, then shades each opaque pixel
// full-bright left of the displayed health and dimmed to its right.
// Ports:
//   clk, reset_n  pixel clock, asynchronous active-low reset
//   bus           renderer side of health_bar_renderer_if
// Latency from x/y to rgb_out/bar_on is two clocks.
module health_bar_renderer
  import fighter_gfx_pkg::*;
#(
  parameter logic [9:0]         X_POS       = 10'd16,
  parameter logic [9:0]         Y_POS       = 10'd16,
  parameter logic [HP_W-1:0]    MAX_HP      = 7'd64,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 12'h000,
  parameter logic [3:0]         STEP_FRAMES = 4'd2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  health_bar_renderer_if.slave  bus
);

  logic [9:0]         dx, dy;
  logic               in_box;
  logic               in_box_q, in_box_d;
  logic [5:0]         col_q, col_d;
  logic               bar_on_q, bar_on_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic [HP_W-1:0]    hp_shown;
  logic               ko;

  // Stage 0: offsets into the sprite. The ">= POS" test guarantees the
  // subtraction did not wrap, so the upper offset bits being zero is
  // exactly "within 64 pixels of the edge".
  always_comb begin
    dx     = bus.x - X_POS;
    dy     = bus.y - Y_POS;
    in_box = bus.video_on &&
             (bus.x >= X_POS) && (dx[9:6] == 4'd0) &&
             (bus.y >= Y_POS) && (dy[9:6] == 4'd0);
  end

  assign bus.rom_row = dy[5:0];
  assign bus.rom_col = dx[5:0];

  // Stage 1 travels alongside the ROM's address register; stage 2 sees
  // rom_data for the same pixel.
  always_comb begin
    in_box_d = in_box;
    col_d    = dx[5:0];
    bar_on_d = in_box_q && (bus.rom_data != TRANSPARENT);
    rgb_d    = '0;
    if (bar_on_d) begin
      rgb_d = ({1'b0, col_q} < hp_shown) ? bus.rom_data : dim(bus.rom_data);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_box_q <= 1'b0;
      col_q    <= '0;
      bar_on_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      in_box_q <= in_box_d;
      col_q    <= col_d;
      bar_on_q <= bar_on_d;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.rgb_out = rgb_q;
  assign bus.bar_on  = bar_on_q;

  hp_animator #(
    .MAX_HP      (MAX_HP),
    .STEP_FRAMES (STEP_FRAMES)
  ) u_hp_animator (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (bus.frame_tick),
    .hp_load      (bus.hp_load),
    .hp_target_in (bus.hp_target_in),
    .hp_shown     (hp_shown),
    .ko           (ko)
  );

  assign bus.hp_shown = hp_shown;
  assign bus.ko       = ko;

endmodule

// File: doc/health_bar_renderer.md
Name: health_bar_renderer

Overview:
- Pixel-stage consumer of the 64x64, 12-bit health-bar sprite ROM.
- Maps the VGA scan position to ROM row/col and absorbs the ROM's 1-cycle registered-address latency.
- Shades the bar by current health, and animates the displayed health toward a target one step per N frames.
- Output feeds the per-player pixel mux ahead of the VGA colour register.

Parameters:
- X_POS, 10'd16, left edge of sprite on screen (pixels)
- Y_POS, 10'd16, top edge of sprite on screen (pixels)
- MAX_HP, 7'd64, full health; equals sprite width
- TRANSPARENT, 12'h000, ROM colour treated as "not drawn"
- STEP_FRAMES, 4'd2, frame_tick pulses per 1-point health step (must be >=1)

Ports:
- clk  in  1  system pixel clock
- reset_n  in  1  asynchronous, active-low reset
- video_on  in  1  VGA active-area flag, aligned with x/y
- x  in  10  current pixel column
- y  in  10  current pixel row
- frame_tick  in  1  one-cycle pulse once per frame (start of vblank)
- hp_load  in  1  one-cycle pulse: latch hp_target_in
- hp_target_in  in  7  new health target, 0..127 accepted, clamped to MAX_HP
- rom_row  out  6  row address to sprite ROM (combinational)
- rom_col  out  6  col address to sprite ROM (combinational)
- rom_data  in  12  ROM colour, valid 1 clk after address
- rgb_out  out  12  pixel colour, registered
- bar_on  out  1  pixel belongs to opaque bar, registered
- hp_shown  out  7  currently displayed health, registered
- ko  out  1  one-cycle pulse when hp_shown reaches 0

Behaviour:
- Reset (async, reset_n=0) forces:
  - rgb_out=0, bar_on=0, ko=0
  - hp_shown=MAX_HP, target=MAX_HP
  - state=IDLE, frame counter=0
  - pipeline valid bits=0
- Stage 0 (comb):
  - in_box = video_on && x in [X_POS, X_POS+63] && y in [Y_POS, Y_POS+63]
  - rom_row=(y-Y_POS)[5:0], rom_col=(x-X_POS)[5:0]; addresses outside the box are don't-care.
- Stage 1 (reg): in_box_d, col_d registered alongside the ROM's internal address register; rom_data is valid this stage.
- Stage 2 (reg):
  - bar_on = in_box_d && rom_data!=TRANSPARENT.
  - rgb_out:
    - zero-extended col_d < hp_shown: rom_data
    - otherwise: each 4-bit channel shifted right 1 (dimmed)
    - bar_on=0: 0
  - Total latency x/y -> rgb_out/bar_on = 2 clk.
- Health FSM states: IDLE, DRAIN, HEAL, KO.
  - hp_load: target <= min(hp_target_in, MAX_HP); frame counter <= 0.
    - Next state: DRAIN if new target < hp_shown; HEAL if >; IDLE if equal.
    - Applies from any state, including KO.
  - DRAIN/HEAL: count frame_tick. On the STEP_FRAMES-th tick, hp_shown -/+ 1 and counter <= 0.
    - Reaching target -> IDLE, except DRAIN reaching 0 -> KO.
  - KO: ko=1 for exactly the entry cycle. Hold until hp_load with nonzero target (-> HEAL). hp_load with 0 stays KO and emits no new ko pulse.
  - hp_load and frame_tick in the same cycle: load wins; that tick is not counted.
  - hp_shown changes only on frame_tick cycles (vblank), so there is no mid-frame tearing.
  - hp_shown never exceeds MAX_HP and never underflows below 0.
- Reset mid-drain: immediately restores full health, IDLE, no ko.

Decomposition:
- Shared package fighter_gfx_pkg holds:
  - SPR_W=64, SPR_H=64, COLOR_W=12, HP_W=7
  - health state encoding: IDLE=2'd0, DRAIN=2'd1, HEAL=2'd2, KO=2'd3
  - dim function (per-channel >>1)
- One natural sub-module: hp_animator, which owns the FSM, frame counter, hp_shown and ko. The renderer top holds the pixel pipeline and instantiates hp_animator; the ROM is instantiated at the player level, not inside this block.

Test Plan:
- Pipeline latency (default params, behavioural ROM model):
  - Stimulus: x=16, y=16 on cycle n.
  - Required: rom_row=0, rom_col=0 on cycle n; rgb_out=ROM[0][0] and bar_on=1 (ROM[0][0]=12'hE00) on cycle n+2.
  - Stimulus: x=80 (out of box). Required: bar_on=0 and rgb_out=0 at n+2.
- Shading:
  - Stimulus: hp_shown=32, pixel col 31 with ROM colour 12'hE00. Required: rgb_out=12'hE00.
  - Stimulus: col 32, same colour. Required: rgb_out=12'h700.
  - Stimulus: ROM colour 12'h000. Required: bar_on=0.
- Drain animation:
  - Stimulus: hp_load with target 60, STEP_FRAMES=2.
  - Required: hp_shown steps 64->63 on the 2nd frame_tick, 63->62 on the 4th, …; reaches 60 after 8 ticks; state IDLE.
- KO:
  - Stimulus: hp_load with target 0 from hp_shown=2.
  - Required: ko high for exactly one cycle, coincident with hp_shown becoming 0 (4th tick). A further hp_load 0 produces no ko. hp_load 20 -> HEAL to 20.
- Clamp and collision:
  - Stimulus: hp_load 100 while at 64. Required: target=64, state IDLE.
  - Stimulus: hp_load coincident with frame_tick. Required: counter=0 and no step that cycle.
- Async reset mid-drain:
  - Stimulus: reset_n low for 3 ns between clock edges. Required: outputs zero immediately, hp_shown=64, no ko on release.
